rr_req_client_mux: RTL and testbench

- Requester side of the round-robin req/gnt interface. Buffers one transaction per client and drives the N-bit req vector to a round-robin arbiter.
- Consumes the arbiter's registered one-hot gnt and moves the granted client's payload onto a single shared valid/ready output stream, tagged with the source index.
- Sits between N client producers and the shared downstream resource that the arbiter protects.

---
 rtl/rr_req_client_mux.sv | 147 ++++++++++++++
 tb/tb_rr_req_client_mux.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_client_mux.sv
// rr_req_client_mux
// Requester side of a round-robin req/gnt pair. Each client owns a one-entry
// slot. Full slots raise req toward an external registered arbiter. The
// granted slot's payload moves onto one shared valid/ready output stream,
// tagged with the source client index.
//
// Optional build macro: RR_REQ_GNT_CHECK_EN
//   Defined   : proto_err is a sticky flag. It is set when gnt is multi-hot, or
//               when gnt names a client that was not requesting in the previous
//               cycle (req_q). It clears only on reset.
//   Undefined : proto_err is tied low and no checker logic is built.
//
// Handshake semantics (input and output streams alike): a beat transfers on
// a clock edge where valid & ready are both high. valid, once raised, stays
// high with data held stable until that transfer. ready may depend on
// registered state only (in_ready) or be driven freely (out_ready).

module rr_req_client_mux #(
  parameter int NUM_CLIENTS = 16,
  parameter int DATA_W      = 8,
  parameter int IDX_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        in_valid,
  input  logic [NUM_CLIENTS*DATA_W-1:0] in_data,
  output logic [NUM_CLIENTS-1:0]        in_ready,
  output logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        gnt,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [IDX_W-1:0]              out_src,
  input  logic                          out_ready,
  output logic                          proto_err
);

  // Slot storage: one buffered transaction per client.
  logic [NUM_CLIENTS-1:0] full;
  logic [DATA_W-1:0]      slot_data [NUM_CLIENTS];

  // Output stage can take a new item when empty or draining this cycle.
  logic                   out_free;

  // Grant qualification.
  logic [NUM_CLIENTS-1:0] gnt_full;
  logic [NUM_CLIENTS-1:0] sel_oh;
  logic [IDX_W-1:0]       sel_idx;
  logic [DATA_W-1:0]      sel_data;
  logic                   sel_found;
  logic                   accept;

  assign out_free = ~out_valid | out_ready;

  // Ready comes straight from the slot register, no bypass, so a popped slot
  // only reopens the cycle after the pop.
  assign in_ready = ~full;

  // Requests are withheld during an output stall so the arbiter never moves
  // its pointer on a grant that cannot be consumed.
  assign req = full & {NUM_CLIENTS{out_free}};

  // Only grants landing on a full slot are meaningful.
  assign gnt_full = gnt & full;

  // Pick the lowest-index full granted client; a well-behaved arbiter gives at
  // most one, and a multi-hot grant still pops exactly one slot.
  always_comb begin
    sel_oh    = '0;
    sel_idx   = '0;
    sel_data  = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt_full[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_oh[i] = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_data  = slot_data[i];
      end
    end
  end

  assign accept = sel_found & out_free;

  // Slot fill on an input handshake, drain on an accepted grant. Both cannot
  // hit one slot in the same cycle: a fill needs the slot empty, a pop full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (accept && sel_oh[i]) begin
          full[i] <= 1'b0;
        end else if (in_valid[i] && !full[i]) begin
          full[i]      <= 1'b1;
          slot_data[i] <= in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Output register: reload on accept (back-to-back if also draining), clear
  // on a drain with nothing new, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= sel_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_REQ_GNT_CHECK_EN
  // The arbiter registers its grant, so gnt answers last cycle's req.
  logic [NUM_CLIENTS-1:0] req_q;
  logic                   gnt_multi;
  logic                   gnt_unreq;
  logic                   proto_err_q;

  assign gnt_multi = |(gnt & (gnt - NUM_CLIENTS'(1)));
  assign gnt_unreq = |(gnt & ~req_q);
  assign proto_err = proto_err_q;

  // Track previous req and latch any grant-protocol violation until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      req_q <= req;
      if (gnt_multi || gnt_unreq) begin
        proto_err_q <= 1'b1;
      end
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_req_client_mux.sv
// tb_rr_req_client_mux
// Bench for rr_req_client_mux: a registered round-robin arbiter model closes
// the req/gnt loop (with a forcing override for protocol corner cases), a
// transaction-level reference model predicts slot occupancy and the output
// stream, and directed sequences pin literal expectations.

module tb_rr_req_client_mux;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int IW = 4;
`ifdef RR_REQ_GNT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_src;
  logic            out_ready;
  logic            proto_err;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  rr_req_client_mux #(.NUM_CLIENTS(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req(req), .gnt(gnt),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .proto_err(proto_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- arbiter model ----------------
  logic         arb_en;
  logic         force_en;
  logic [N-1:0] force_gnt;
  logic [N-1:0] arb_gnt;
  int           arb_ptr;
  logic [N-1:0] a_nxt;
  int           a_gi;
  logic         a_found;

  assign gnt = force_en ? force_gnt : arb_gnt;

  // Registered round robin; a cycle after any grant it always grants nothing.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_gnt <= '0;
      arb_ptr <= N - 1;
    end else if (!arb_en || arb_gnt != '0) begin
      arb_gnt <= '0;
    end else begin
      a_nxt   = '0;
      a_found = 1'b0;
      a_gi    = 0;
      for (int k = 1; k <= N; k++) begin
        if (req[(arb_ptr + k) % N] && !a_found) begin
          a_found = 1'b1;
          a_gi    = (arb_ptr + k) % N;
        end
      end
      if (a_found) begin
        a_nxt[a_gi] = 1'b1;
        arb_ptr <= a_gi;
      end
      arb_gnt <= a_nxt;
    end
  end

  // ---------------- reference model ----------------
  logic [N-1:0]    m_full;
  logic [DW-1:0]   m_data [N];
  logic            m_ov;
  logic [DW-1:0]   m_od;
  logic [IW-1:0]   m_os;
  logic            m_err;
  logic [N-1:0]    m_req_prev;
  logic [IW+DW-1:0] exp_q[$];
  int              m_sel;
  logic            m_free;
  logic [N-1:0]    m_nfull;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full     <= '0;
      m_ov       <= 1'b0;
      m_od       <= '0;
      m_os       <= '0;
      m_err      <= 1'b0;
      m_req_prev <= '0;
      for (int i = 0; i < N; i++) m_data[i] <= '0;
      exp_q.delete();
    end else begin
      m_free  = !m_ov || out_ready;
      m_nfull = m_full;
      m_sel   = -1;
      for (int i = N - 1; i >= 0; i--) begin
        if (gnt[i] && m_full[i]) m_sel = i;
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && !m_full[i]) begin
          m_nfull[i] = 1'b1;
          m_data[i] <= in_data[i*DW +: DW];
        end
      end
      if (m_sel >= 0 && m_free) begin
        m_nfull[m_sel] = 1'b0;
        m_ov <= 1'b1;
        m_od <= m_data[m_sel];
        m_os <= IW'(m_sel);
        exp_q.push_back({IW'(m_sel), m_data[m_sel]});
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
      m_full <= m_nfull;
      if (CHK_EN && ($countones(gnt) > 1 || (gnt & ~m_req_prev) != '0)) m_err <= 1'b1;
      m_req_prev <= m_full & {N{m_free}};
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  logic [IW-1:0]    log_src[$];
  logic [DW-1:0]    log_data[$];
  int               log_cyc[$];
  logic             c_free;
  logic [N-1:0]     c_rdy;
  logic [N-1:0]     c_req;
  logic [IW+DW-1:0] c_e;

  // Per-cycle comparison against the model plus output-stream scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      c_free = !m_ov || out_ready;
      c_rdy  = ~m_full;
      c_req  = m_full & {N{c_free}};
      check("cmp_out_valid", out_valid, m_ov);
      check("cmp_in_ready", in_ready, c_rdy);
      check("cmp_req", req, c_req);
      check("cmp_proto_err", proto_err, m_err);
      if (m_ov) begin
        check("cmp_out_data", out_data, m_od);
        check("cmp_out_src", out_src, m_os);
      end
      if (out_valid && out_ready) begin
        log_src.push_back(out_src);
        log_data.push_back(out_data);
        log_cyc.push_back(cyc_cnt);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_item", {out_src, out_data}, 32'hFFFF_FFFF);
        end else begin
          c_e = exp_q.pop_front();
          check("sb_item", {out_src, out_data}, c_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    force_en = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] v);
    in_data[idx*DW +: DW] = v;
  endtask

  task automatic wait_ov(input string nm, input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check(nm, out_valid, 1);
  endtask

  int ls;

  // ---------------- directed sequences ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    arb_en    = 1'b1;
    force_en  = 1'b0;
    force_gnt = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_in_ready", in_ready, 32'h0000_FFFF);
    check("rst_req", req, 0);
    check("rst_proto_err", proto_err, 0);
    do_reset();

    // Single client latency: t load, t+1 req, t+2 gnt, t+3 output.
    set_data(3, 8'hA5);
    in_valid = 16'h0008;
    @(negedge clk);
    check("t1_ready_t", in_ready[3], 1);
    cyc();
    in_valid = '0;
    @(negedge clk);
    check("t1_req_t1", req, 32'h0008);
    check("t1_ready_t1", in_ready[3], 0);
    cyc();
    @(negedge clk);
    check("t1_ov_t2", out_valid, 0);
    cyc();
    @(negedge clk);
    check("t1_ov_t3", out_valid, 1);
    check("t1_data_t3", out_data, 8'hA5);
    check("t1_src_t3", out_src, 3);
    check("t1_ready_t3", in_ready[3], 1);
    repeat (3) cyc();

    // Three clients loaded together drain in order 0, 5, 15, two cycles apart.
    do_reset();
    ls = log_src.size();
    set_data(0, 8'h11);
    set_data(5, 8'h55);
    set_data(15, 8'hF0);
    in_valid = 16'h8021;
    cyc();
    in_valid = '0;
    repeat (10) cyc();
    @(negedge clk);
    check("t2_count", log_src.size() - ls, 3);
    if (log_src.size() >= ls + 3) begin
      check("t2_src0", log_src[ls], 0);
      check("t2_src1", log_src[ls+1], 5);
      check("t2_src2", log_src[ls+2], 15);
      check("t2_data2", log_data[ls+2], 8'hF0);
      check("t2_gap01", log_cyc[ls+1] - log_cyc[ls], 2);
      check("t2_gap12", log_cyc[ls+2] - log_cyc[ls+1], 2);
    end
    check("t2_all_empty", in_ready, 32'h0000_FFFF);

    // Output stall: requests drop, output holds, then drains without loss.
    do_reset();
    ls = log_src.size();
    out_ready = 1'b0;
    set_data(1, 8'h21);
    set_data(2, 8'h32);
    set_data(6, 8'h76);
    in_valid = 16'h0046;
    cyc();
    in_valid = '0;
    wait_ov("t3_first_out", 10);
    check("t3_first_src", out_src, 1);
    check("t3_first_data", out_data, 8'h21);
    repeat (3) begin
      cyc();
      @(negedge clk);
      check("t3_stall_req", req, 0);
      check("t3_stall_src", out_src, 1);
      check("t3_stall_data", out_data, 8'h21);
    end
    cyc();
    force_en  = 1'b1;
    force_gnt = 16'h0004;
    cyc();
    force_en = 1'b0;
    @(negedge clk);
    check("t3_stall_gnt_kept", in_ready[2], 0);
    check("t3_stall_gnt_src", out_src, 1);
    check("t3_stall_gnt_err", proto_err, CHK_EN);
    cyc();
    out_ready = 1'b1;
    repeat (12) cyc();
    @(negedge clk);
    check("t3_count", log_src.size() - ls, 3);
    if (log_src.size() >= ls + 3) begin
      check("t3_src0", log_src[ls], 1);
      check("t3_src1", log_src[ls+1], 2);
      check("t3_src2", log_src[ls+2], 6);
      check("t3_data2", log_data[ls+2], 8'h76);
    end
    check("t3_all_empty", in_ready, 32'h0000_FFFF);

    // Grant to an empty client: no pop, optional sticky error.
    do_reset();
    arb_en = 1'b0;
    set_data(2, 8'h42);
    in_valid = 16'h0004;
    cyc();
    in_valid = '0;
    cyc();
    force_en  = 1'b1;
    force_gnt = 16'h0010;
    cyc();
    force_en = 1'b0;
    @(negedge clk);
    check("t4_no_out", out_valid, 0);
    check("t4_full_kept", in_ready, 32'h0000_FFFB);
    check("t4_err", proto_err, CHK_EN);
    repeat (3) cyc();
    @(negedge clk);
    check("t4_err_sticky", proto_err, CHK_EN);

    // Multi-hot grant: only the lowest full granted client pops.
    do_reset();
    arb_en = 1'b0;
    set_data(0, 8'h0A);
    set_data(1, 8'h1B);
    in_valid = 16'h0003;
    cyc();
    in_valid = '0;
    cyc();
    force_en  = 1'b1;
    force_gnt = 16'h0003;
    cyc();
    force_en = 1'b0;
    @(negedge clk);
    check("t5_ov", out_valid, 1);
    check("t5_src", out_src, 0);
    check("t5_data", out_data, 8'h0A);
    check("t5_ready0", in_ready[0], 1);
    check("t5_ready1", in_ready[1], 0);
    check("t5_err", proto_err, CHK_EN);
    arb_en = 1'b1;
    repeat (8) cyc();
    @(negedge clk);
    check("t5_drained", in_ready, 32'h0000_FFFF);

    // Reset mid-stream discards slots and the pending output.
    do_reset();
    for (int i = 7; i <= 11; i++) set_data(i, DW'(8'h70 + i));
    in_valid = 16'h0F80;
    cyc();
    in_valid = '0;
    wait_ov("t6_ov_before", 10);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ov", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_src", out_src, 0);
    check("t6_rst_ready", in_ready, 32'h0000_FFFF);
    check("t6_rst_req", req, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    ls = log_src.size();
    repeat (8) cyc();
    @(negedge clk);
    check("t6_no_stale", log_src.size() - ls, 0);
    check("t6_ov_after", out_valid, 0);
    check("t6_ready_after", in_ready, 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
